ahb_ri5cy_ifetch_bridge: RTL and testbench

//  RI5CY instruction-fetch port (req/gnt/rvalid) to AHB-Lite master bridge.

---
 rtl/ahb_pkg.sv | 18 +
 rtl/ahb_ri5cy_ifetch_bridge_if.sv | 30 +++
 rtl/ahb_wait_watchdog.sv | 47 ++++
 rtl/ahb_ri5cy_ifetch_bridge.sv | 136 +++++++++++++
 tb/tb_ahb_ri5cy_ifetch_bridge.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the instruction-fetch bridge state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // LERR is only reachable when IFETCH_MISALIGN_CHK_EN is defined.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ERR2 = 2'd2,
    LERR = 2'd3
  } ifetch_st_t;

endpackage

// File: rtl/ahb_ri5cy_ifetch_bridge_if.sv
// AHB-Lite master-side bus bundle for the instruction-fetch bridge.
// Signal names keep the bridge's point of view (_o driven by master).
interface ahb_ri5cy_ifetch_bridge_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  logic [AW-1:0] haddr_o;
  logic [1:0]    htrans_o;
  logic          hwrite_o;
  logic [2:0]    hsize_o;
  logic [2:0]    hburst_o;
  logic [3:0]    hprot_o;
  logic          hmastlock_o;
  logic [DW-1:0] hwdata_o;
  logic          hready_i;
  logic [DW-1:0] hrdata_i;
  logic          hresp_i;

  modport master (
    output haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hprot_o, hmastlock_o, hwdata_o,
    input  hready_i, hrdata_i, hresp_i
  );

  modport slave (
    input  haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hprot_o, hmastlock_o, hwdata_o,
    output hready_i, hrdata_i, hresp_i
  );

endinterface

// File: rtl/ahb_wait_watchdog.sv
// Counts consecutive stalled data-phase cycles and raises a sticky flag once the
// count reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 removes the counter entirely.
module ahb_wait_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_i,
  output logic timeout_o
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk, rst, stall_i};
    assign timeout_o = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q;

    // Saturating count of consecutive stall cycles; any non-stall cycle restarts it.
    always_comb begin
      cnt_d = '0;
      if (stall_i) begin
        cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
      end
    end

    // Counter and sticky flag, both cleared only by reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        to_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        if (cnt_d == LIMIT) begin
          to_q <= 1'b1;
        end
      end
    end

    assign timeout_o = to_q;
  end

endmodule

// File: rtl/ahb_ri5cy_ifetch_bridge.sv
// RI5CY instruction-fetch (req/gnt/rvalid) to AHB-Lite master bridge.
// Single-word NONSEQ reads; the next address phase overlaps the current data phase.
// Optional build macro: IFETCH_MISALIGN_CHK_EN -- misaligned fetches are answered
// locally with an error instead of fetching the enclosing aligned word.
module ahb_ri5cy_ifetch_bridge
  import ahb_pkg::*;
#(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL      = 4'b0010,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_i,
  input  logic [31:0]                 addr_i,
  output logic                        gnt_o,
  output logic                        rvalid_o,
  output logic [31:0]                 rdata_o,
  output logic                        err_o,
  output logic                        timeout_o,
  ahb_ri5cy_ifetch_bridge_if.master   ahb
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_DATA = DATA;
  localparam logic [1:0] ST_ERR2 = ERR2;
`ifdef IFETCH_MISALIGN_CHK_EN
  localparam logic [1:0] ST_LERR = LERR;
`endif

  logic [1:0] state_q, state_d;
  logic       stall;

  // Fixed attributes of every transfer this master issues.
  assign ahb.haddr_o     = AHB_ADDR_WIDTH'({addr_i[31:2], 2'b00});
  assign ahb.hwrite_o    = 1'b0;
  assign ahb.hsize_o     = HSIZE_WORD;
  assign ahb.hburst_o    = HBURST_SINGLE;
  assign ahb.hprot_o     = HPROT_VAL;
  assign ahb.hmastlock_o = 1'b0;
  assign ahb.hwdata_o    = {AHB_DATA_WIDTH{1'b0}};
  assign rdata_o         = 32'(ahb.hrdata_i);

`ifndef IFETCH_MISALIGN_CHK_EN
  // Byte offset is irrelevant when the aligned word is always fetched.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];
`endif

  // Response decode, address-phase issue and next-state selection.
  always_comb begin
    logic err_first;
    state_d      = state_q;
    gnt_o        = 1'b0;
    rvalid_o     = 1'b0;
    err_o        = 1'b0;
    ahb.htrans_o = HTRANS_IDLE;
    // First ERROR cycle: the pipelined address phase must be cancelled.
    err_first    = (state_q == ST_DATA) && ahb.hresp_i;
    stall        = ((state_q == ST_DATA) || (state_q == ST_ERR2)) && !ahb.hready_i;

    // Data-phase completion; with no new grant the bridge falls back to IDLE.
    unique case (state_q)
      ST_DATA: begin
        if (ahb.hresp_i) begin
          state_d = ST_ERR2;
        end else if (ahb.hready_i) begin
          rvalid_o = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_ERR2: begin
        if (ahb.hready_i) begin
          rvalid_o = 1'b1;
          err_o    = 1'b1;
          state_d  = ST_IDLE;
        end
      end
`ifdef IFETCH_MISALIGN_CHK_EN
      ST_LERR: begin
        rvalid_o = 1'b1;
        err_o    = 1'b1;
        state_d  = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // A new request overrides the fall-back so fetches can run back-to-back.
    if (req_i) begin
`ifdef IFETCH_MISALIGN_CHK_EN
      if (addr_i[1:0] != 2'b00) begin
        // Never reaches the bus; answered next cycle from LERR.
        gnt_o = ahb.hready_i;
        if (gnt_o) begin
          state_d = ST_LERR;
        end
      end else
`endif
      if (!err_first) begin
        ahb.htrans_o = HTRANS_NONSEQ;
        gnt_o        = ahb.hready_i;
        if (gnt_o) begin
          state_d = ST_DATA;
        end
      end
    end

    if (rst) begin
      gnt_o        = 1'b0;
      rvalid_o     = 1'b0;
      err_o        = 1'b0;
      ahb.htrans_o = HTRANS_IDLE;
    end
  end

  // State register; reset drops any fetch still in its data phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  ahb_wait_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .stall_i  (stall),
    .timeout_o(timeout_o)
  );

endmodule

// File: tb/tb_ahb_ri5cy_ifetch_bridge.sv
// Self-checking bench for ahb_ri5cy_ifetch_bridge: cycle tables for the basic
// fetch patterns, hand sequences for timeout / reset / misalignment, then a
// randomized run against a pending-fetch reference model.
module tb_ahb_ri5cy_ifetch_bridge;

  localparam int unsigned TO = 8;
  localparam logic [1:0]  NS = 2'b10;
  localparam logic [1:0]  ID = 2'b00;
`ifdef IFETCH_MISALIGN_CHK_EN
  localparam bit MIS_CHK = 1'b1;
`else
  localparam bit MIS_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        gnt, rvalid, err, timeout;
  logic [31:0] rdata;

  int checks   = 0;
  int failures = 0;

  ahb_ri5cy_ifetch_bridge_if #(.AW(32), .DW(32)) bus ();

  ahb_ri5cy_ifetch_bridge #(
    .AHB_ADDR_WIDTH(32),
    .AHB_DATA_WIDTH(32),
    .HPROT_VAL     (4'b0010),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .addr_i   (addr),
    .gnt_o    (gnt),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err),
    .timeout_o(timeout),
    .ahb      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, req;
    logic [31:0] addr;
    logic        hready, hresp;
    logic [31:0] hrdata;
    logic        gnt, rvalid, err;
    logic [1:0]  htrans;
    logic [31:0] rdata;
  } vec_t;

  vec_t vq[$];

  typedef struct {
    bit local_err;
    bit err_seen;
  } pend_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic r, input logic q, input logic [31:0] a, input logic hr,
                       input logic hs, input logic [31:0] hd);
    @(negedge clk);
    rst          = r;
    req          = q;
    addr         = a;
    bus.hready_i = hr;
    bus.hresp_i  = hs;
    bus.hrdata_i = hd;
    #1;
  endtask

  task automatic add(input string n, input logic r, input logic q, input logic [31:0] a,
                     input logic hr, input logic hs, input logic [31:0] hd, input logic g,
                     input logic rv, input logic e, input logic [1:0] ht,
                     input logic [31:0] rd);
    vq.push_back('{n, r, q, a, hr, hs, hd, g, rv, e, ht, rd});
  endtask

  initial begin
    pend_t       pq[$];
    int          wait_run;
    bit          exp_to, hold;
    logic        r_r, q_r, hr_r, hs_r;
    logic [31:0] a_r, hd_r;

    rst = 1'b1; req = 1'b0; addr = '0;
    bus.hready_i = 1'b1; bus.hresp_i = 1'b0; bus.hrdata_i = '0;

    // ---------------- cycle tables ----------------
    add("rst",       1, 1, 32'h80, 1, 0, 32'h0,       0, 0, 0, ID, 32'h0);
    add("t1.addr",   0, 1, 32'h80, 1, 0, 32'h0,       1, 0, 0, NS, 32'h0);
    add("t1.data",   0, 0, 32'h0,  1, 0, 32'h6F,      0, 1, 0, ID, 32'h6F);
    add("t1.idle",   0, 0, 32'h0,  1, 0, 32'h11,      0, 0, 0, ID, 32'h0);
    add("t2.a80",    0, 1, 32'h80, 1, 0, 32'h0,       1, 0, 0, NS, 32'h0);
    add("t2.a84",    0, 1, 32'h84, 1, 0, 32'hA0,      1, 1, 0, NS, 32'hA0);
    add("t2.a88",    0, 1, 32'h88, 1, 0, 32'hA1,      1, 1, 0, NS, 32'hA1);
    add("t2.a8c",    0, 1, 32'h8C, 1, 0, 32'hA2,      1, 1, 0, NS, 32'hA2);
    add("t2.d8c",    0, 0, 32'h0,  1, 0, 32'hA3,      0, 1, 0, ID, 32'hA3);
    add("t3.a84",    0, 1, 32'h84, 1, 0, 32'h0,       1, 0, 0, NS, 32'h0);
    for (int i = 0; i < 3; i++) begin
      add("t3.wait", 0, 1, 32'h88, 0, 0, 32'hBAD,     0, 0, 0, NS, 32'h0);
    end
    add("t3.d84",    0, 1, 32'h88, 1, 0, 32'h1184,    1, 1, 0, NS, 32'h1184);
    add("t3.d88",    0, 0, 32'h0,  1, 0, 32'h1188,    0, 1, 0, ID, 32'h1188);
    add("t4.a90",    0, 1, 32'h90, 1, 0, 32'h0,       1, 0, 0, NS, 32'h0);
    add("t4.err1",   0, 1, 32'h94, 0, 1, 32'h0,       0, 0, 0, ID, 32'h0);
    add("t4.err2",   0, 1, 32'h94, 1, 1, 32'h0,       1, 1, 1, NS, 32'h0);
    add("t4.d94",    0, 0, 32'h0,  1, 0, 32'h94,      0, 1, 0, ID, 32'h94);
    add("hr0.idle",  0, 1, 32'hA0, 0, 0, 32'h0,       0, 0, 0, NS, 32'h0);
    add("hr0.gnt",   0, 1, 32'hA0, 1, 0, 32'h0,       1, 0, 0, NS, 32'h0);
    add("hr0.data",  0, 0, 32'h0,  1, 0, 32'hA0A0,    0, 1, 0, ID, 32'hA0A0);
    add("drop.req",  0, 1, 32'hB0, 0, 0, 32'h0,       0, 0, 0, NS, 32'h0);
    add("drop.idle", 0, 0, 32'h0,  1, 0, 32'h5,       0, 0, 0, ID, 32'h0);

    drive(1, 0, 0, 1, 0, 0);
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].req, vq[i].addr, vq[i].hready, vq[i].hresp, vq[i].hrdata);
      chk({vq[i].name, ".gnt"},    gnt,          vq[i].gnt);
      chk({vq[i].name, ".rvalid"}, rvalid,       vq[i].rvalid);
      chk({vq[i].name, ".err"},    err,          vq[i].err);
      chk({vq[i].name, ".htrans"}, bus.htrans_o, vq[i].htrans);
      if (vq[i].req) chk({vq[i].name, ".haddr"}, bus.haddr_o, vq[i].addr & ~32'h3);
      if (vq[i].rvalid && !vq[i].err) chk({vq[i].name, ".rdata"}, rdata, vq[i].rdata);
    end

    chk("const.hwrite",    bus.hwrite_o,    0);
    chk("const.hsize",     bus.hsize_o,     3'b010);
    chk("const.hburst",    bus.hburst_o,    0);
    chk("const.hprot",     bus.hprot_o,     4'b0010);
    chk("const.hmastlock", bus.hmastlock_o, 0);
    chk("const.hwdata",    bus.hwdata_o,    0);
    chk("to.none",         timeout,         0);

    // ---------------- timeout: 10 wait states, limit 8 ----------------
    drive(0, 1, 32'h100, 1, 0, 0);
    chk("to.gnt", gnt, 1);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk("to.wait.flag", timeout, (k >= 9) ? 1 : 0);
      chk("to.wait.rvalid", rvalid, 0);
    end
    drive(0, 0, 0, 1, 0, 32'hCAFE);
    chk("to.done.rvalid", rvalid, 1);
    chk("to.done.rdata", rdata, 32'hCAFE);
    chk("to.done.flag", timeout, 1);
    drive(0, 0, 0, 1, 0, 0);
    chk("to.sticky", timeout, 1);
    drive(1, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("to.cleared", timeout, 0);

    // ---------------- reset mid-data, then misaligned fetch ----------------
    drive(0, 1, 32'h200, 1, 0, 0);
    chk("rstd.gnt", gnt, 1);
    drive(1, 0, 0, 1, 0, 32'hDEAD);
    chk("rstd.rvalid.inrst", rvalid, 0);
    drive(0, 0, 0, 1, 0, 32'hBEEF);
    chk("rstd.rvalid.after", rvalid, 0);
    drive(0, 1, 32'h82, 1, 0, 0);
    chk("mis.gnt", gnt, 1);
    chk("mis.htrans", bus.htrans_o, MIS_CHK ? ID : NS);
    chk("mis.haddr", bus.haddr_o, 32'h80);
    drive(0, 0, 0, 1, 0, 32'h77);
    chk("mis.rvalid", rvalid, 1);
    chk("mis.err", err, MIS_CHK ? 1 : 0);
    if (!MIS_CHK) chk("mis.rdata", rdata, 32'h77);
    drive(0, 0, 0, 1, 0, 0);
    chk("mis.idle", rvalid, 0);

    // ---------------- randomized run against the reference model ----------------
    drive(1, 0, 0, 1, 0, 0);
    wait_run = 0; exp_to = 0; hold = 0; q_r = 0; a_r = '0;
    for (int n = 0; n < 3000; n++) begin
      bit busy_bus, mis, err_first, e_gnt, e_rv, e_err, e_ns, done, mark;
      r_r = ($urandom_range(0, 199) == 0);
      if (!(hold && ($urandom_range(0, 9) != 0))) begin
        q_r = ($urandom_range(0, 9) < 7);
        a_r = $urandom & 32'h0000_FFFF;
      end
      busy_bus = (pq.size() != 0) && !pq[0].local_err;
      if (busy_bus && pq[0].err_seen) begin
        hr_r = ($urandom_range(0, 3) != 0); hs_r = 1;
      end else if (busy_bus) begin
        case ($urandom_range(0, 7))
          0:       begin hr_r = 0; hs_r = 1; end
          1, 2:    begin hr_r = 0; hs_r = 0; end
          default: begin hr_r = 1; hs_r = 0; end
        endcase
      end else begin
        hr_r = ($urandom_range(0, 3) != 0); hs_r = 0;
      end
      hd_r = $urandom;
      drive(r_r, q_r, a_r, hr_r, hs_r, hd_r);

      mis       = MIS_CHK && (a_r[1:0] != 2'b00);
      err_first = busy_bus && !pq[0].err_seen && hs_r;
      e_gnt     = q_r && hr_r && (mis || !err_first);
      e_ns      = q_r && !mis && !err_first;
      e_rv = 0; e_err = 0; done = 0; mark = 0;
      if (pq.size() != 0) begin
        if (pq[0].local_err) begin
          e_rv = 1; e_err = 1; done = 1;
        end else if (pq[0].err_seen) begin
          if (hr_r) begin e_rv = 1; e_err = 1; done = 1; end
        end else if (hs_r) begin
          mark = 1;
        end else if (hr_r) begin
          e_rv = 1; done = 1;
        end
      end
      if (r_r) begin e_gnt = 0; e_rv = 0; e_err = 0; e_ns = 0; end

      chk("rnd.gnt", gnt, e_gnt);
      chk("rnd.rvalid", rvalid, e_rv);
      chk("rnd.err", err, e_err);
      chk("rnd.htrans", bus.htrans_o, e_ns ? NS : ID);
      chk("rnd.timeout", timeout, exp_to);
      if (q_r) chk("rnd.haddr", bus.haddr_o, a_r & ~32'h3);
      if (e_rv && !e_err) chk("rnd.rdata", rdata, hd_r);

      if (r_r) begin
        pq.delete(); wait_run = 0; exp_to = 0; hold = 0;
      end else begin
        wait_run = (busy_bus && !hr_r) ? wait_run + 1 : 0;
        if (wait_run >= TO) exp_to = 1;
        if (done) void'(pq.pop_front());
        if (mark) pq[0].err_seen = 1;
        if (e_gnt) pq.push_back('{mis, 1'b0});
        hold = q_r && !e_gnt;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
